// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, mul/div select.
package alu_seq_pkg;

    localparam logic [3:0] CTRL_ALU_ADD = 4'd0;
    localparam logic [3:0] CTRL_ALU_SUB = 4'd1;
    localparam logic [3:0] CTRL_ALU_AND = 4'd2;
    localparam logic [3:0] CTRL_ALU_OR  = 4'd3;
    localparam logic [3:0] CTRL_ALU_XOR = 4'd4;
    localparam logic [3:0] CTRL_ALU_NOR = 4'd5;
    localparam logic [3:0] CTRL_ALU_SLL = 4'd6;
    localparam logic [3:0] CTRL_ALU_SRL = 4'd7;
    localparam logic [3:0] CTRL_ALU_SRA = 4'd8;
    localparam logic [3:0] CTRL_ALU_ROL = 4'd9;
    localparam logic [3:0] CTRL_ALU_ROR = 4'd10;
    localparam logic [3:0] CTRL_ALU_SLT = 4'd11;
    localparam logic [3:0] CTRL_ALU_NEG = 4'd12;
    localparam logic [3:0] CTRL_ALU_MUL = 4'd13;
    localparam logic [3:0] CTRL_ALU_DIV = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_op_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == CTRL_ALU_MUL) || (op == CTRL_ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one register pair.
// Latency WIDTH/BITS_PER_CYCLE cycles after load; fin marks the final iteration edge.
module alu_muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             fin,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam int AW    = WIDTH + BITS_PER_CYCLE;

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_t           op_q, op_d;

    logic [AW-1:0]    partial, acc;
    logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;

    // Multiply: hi accumulates, lo holds the not-yet-consumed multiplier bits.
    always_comb begin
        partial = '0;
        if (lo_q[0])
            partial = partial + AW'(b_q);
        if (BITS_PER_CYCLE == 2 && lo_q[1])
            partial = partial + AW'({b_q, 1'b0});
        acc    = AW'(hi_q) + partial;
        mul_hi = acc[AW-1:BITS_PER_CYCLE];
        mul_lo = {acc[BITS_PER_CYCLE-1:0], lo_q[WIDTH-1:BITS_PER_CYCLE]};
    end

    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        rem = {1'b0, hi_q};
        quo = lo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem = {rem[WIDTH-1:0], quo[WIDTH-1]};
            quo = {quo[WIDTH-2:0], 1'b0};
            if (rem >= {1'b0, b_q}) begin
                rem    = rem - {1'b0, b_q};
                quo[0] = 1'b1;
            end
        end
        div_hi = rem[WIDTH-1:0];
        div_lo = quo;
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        op_d  = op_q;
        cnt_d = cnt_q;
        if (load) begin
            hi_d  = '0;
            lo_d  = a_mag;
            b_d   = b_mag;
            op_d  = op;
            cnt_d = CNT_W'(N);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (op_q == MD_MUL) begin
                hi_d = mul_hi;
                lo_d = mul_lo;
            end else begin
                hi_d = div_hi;
                lo_d = div_lo;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            op_q  <= MD_MUL;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
        end
    end

    assign fin    = (cnt_q == CNT_W'(1));
    assign res_hi = hi_q;
    assign res_lo = lo_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops in 1 cycle, signed MUL/DIV on an iterative core in N+2.
// oBusy high during ITER/FIX; iStart is only sampled when not busy and is dropped otherwise.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [3:0]       iCtrl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oC_hi,
    output logic [WIDTH-1:0] oC_lo,
    output logic             oZero,
    output logic             oNeg,
    output logic             oCarry,
    output logic             oOverflow,
    output logic             oDivZero
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    md_op_t           md_op_q, md_op_d;
    logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;

    logic [WIDTH-1:0] c_hi_q, c_hi_d, c_lo_q, c_lo_d;
    logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
    logic             ovf_q, ovf_d, divz_q, divz_d, busy_q, busy_d, done_q, done_d;

    logic [SHAMT_W-1:0] sh;
    logic [WIDTH-1:0]   add_x, add_y, sum;
    logic               add_cin;
    logic [WIDTH:0]     add_ext;
    logic [2*WIDTH-1:0] rot_l, rot_r;
    logic [WIDTH-1:0]   sc_lo;
    logic               sc_arith, sc_ovf;

    logic             md_load, md_fin;
    logic [WIDTH-1:0] a_mag, b_mag, md_hi, md_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, fix_hi, fix_lo;

    assign a_mag = iA[WIDTH-1] ? -iA : iA;
    assign b_mag = iB[WIDTH-1] ? -iB : iB;

    alu_muldiv_iter #(
        .WIDTH         (WIDTH),
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_muldiv (
        .clk   (iClk),
        .rst   (iRst),
        .load  (md_load),
        .op    (md_op_d),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .fin   (md_fin),
        .res_hi(md_hi),
        .res_lo(md_lo)
    );

    always_comb begin
        sh      = iB[SHAMT_W-1:0];
        add_x   = iA;
        add_y   = iB;
        add_cin = 1'b0;
        case (iCtrl)
            CTRL_ALU_SUB: begin
                add_y   = ~iB;
                add_cin = 1'b1;
            end
            CTRL_ALU_NEG: begin
                add_x   = '0;
                add_y   = ~iA;
                add_cin = 1'b1;
            end
            default: ;
        endcase
        add_ext = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
        sum     = add_ext[WIDTH-1:0];
        sc_ovf  = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
        rot_l   = {iA, iA} << sh;
        rot_r   = {iA, iA} >> sh;

        sc_lo    = '0;
        sc_arith = 1'b0;
        case (iCtrl)
            CTRL_ALU_ADD, CTRL_ALU_SUB, CTRL_ALU_NEG: begin
                sc_lo    = sum;
                sc_arith = 1'b1;
            end
            CTRL_ALU_AND: sc_lo = iA & iB;
            CTRL_ALU_OR:  sc_lo = iA | iB;
            CTRL_ALU_XOR: sc_lo = iA ^ iB;
            CTRL_ALU_NOR: sc_lo = ~(iA | iB);
            CTRL_ALU_SLL: sc_lo = iA << sh;
            CTRL_ALU_SRL: sc_lo = iA >> sh;
            CTRL_ALU_SRA: sc_lo = $signed(iA) >>> sh;
            CTRL_ALU_ROL: sc_lo = rot_l[2*WIDTH-1:WIDTH];
            CTRL_ALU_ROR: sc_lo = rot_r[WIDTH-1:0];
            CTRL_ALU_SLT: sc_lo = {{(WIDTH-1){1'b0}}, $signed(iA) < $signed(iB)};
            default:      sc_lo = '0;
        endcase
    end

    // Sign correction of the unsigned core result; divide-by-zero bypasses the core value.
    always_comb begin
        prod     = {md_hi, md_lo};
        prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
        quo_fix  = (a_neg_q ^ b_neg_q) ? -md_lo : md_lo;
        rem_fix  = a_neg_q ? -md_hi : md_hi;
        if (md_op_q == MD_MUL) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else if (div_zero_q) begin
            fix_hi = '1;
            fix_lo = a_raw_q;
        end else begin
            fix_hi = quo_fix;
            fix_lo = rem_fix;
        end
    end

    always_comb begin
        state_d    = state_q;
        md_op_d    = md_op_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        div_zero_d = div_zero_q;
        a_raw_d    = a_raw_q;
        c_hi_d     = c_hi_q;
        c_lo_d     = c_lo_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        divz_d     = divz_q;
        md_load    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (iStart) begin
                    if (is_muldiv(iCtrl)) begin
                        state_d    = ST_ITER;
                        md_load    = 1'b1;
                        md_op_d    = (iCtrl == CTRL_ALU_DIV) ? MD_DIV : MD_MUL;
                        a_neg_d    = iA[WIDTH-1];
                        b_neg_d    = iB[WIDTH-1];
                        div_zero_d = (iCtrl == CTRL_ALU_DIV) && (iB == '0);
                        a_raw_d    = iA;
                    end else begin
                        state_d = ST_DONE;
                        c_hi_d  = '0;
                        c_lo_d  = sc_lo;
                        zero_d  = (sc_lo == '0);
                        neg_d   = sc_lo[WIDTH-1];
                        carry_d = sc_arith & add_ext[WIDTH];
                        ovf_d   = sc_arith & sc_ovf;
                        divz_d  = 1'b0;
                    end
                end
            end
            ST_ITER: begin
                if (md_fin)
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_DONE;
                c_hi_d  = fix_hi;
                c_lo_d  = fix_lo;
                zero_d  = ({fix_hi, fix_lo} == '0);
                neg_d   = fix_hi[WIDTH-1];
                carry_d = 1'b0;
                ovf_d   = 1'b0;
                divz_d  = (md_op_q == MD_DIV) && div_zero_q;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_ITER) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            md_op_q    <= MD_MUL;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= '0;
            c_hi_q     <= '0;
            c_lo_q     <= '0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            divz_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            md_op_q    <= md_op_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            div_zero_q <= div_zero_d;
            a_raw_q    <= a_raw_d;
            c_hi_q     <= c_hi_d;
            c_lo_q     <= c_lo_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            divz_q     <= divz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oC_hi     = c_hi_q;
    assign oC_lo     = c_lo_q;
    assign oZero     = zero_q;
    assign oNeg      = neg_q;
    assign oCarry    = carry_q;
    assign oOverflow = ovf_q;
    assign oDivZero  = divz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors, expectations queued at issue, checked on oDone.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start1 = 1'b0, start2 = 1'b0;
    logic [3:0]   ctrl = 4'd0;
    logic [W-1:0] a = '0, b = '0;

    logic         busy1, done1, zero1, neg1, carry1, ovf1, dz1;
    logic [W-1:0] hi1, lo1;
    logic         busy2, done2, zero2, neg2, carry2, ovf2, dz2;
    logic [W-1:0] hi2, lo2;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
        .iClk(clk), .iRst(rst), .iStart(start1), .iCtrl(ctrl), .iA(a), .iB(b),
        .oBusy(busy1), .oDone(done1), .oC_hi(hi1), .oC_lo(lo1), .oZero(zero1),
        .oNeg(neg1), .oCarry(carry1), .oOverflow(ovf1), .oDivZero(dz1)
    );

    alu_seq #(.WIDTH(W), .BITS_PER_CYCLE(2)) dut2 (
        .iClk(clk), .iRst(rst), .iStart(start2), .iCtrl(ctrl), .iA(a), .iB(b),
        .oBusy(busy2), .oDone(done2), .oC_hi(hi2), .oC_lo(lo2), .oZero(zero2),
        .oNeg(neg2), .oCarry(carry2), .oOverflow(ovf2), .oDivZero(dz2)
    );

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [4:0]   flags;   // {zero, neg, carry, ovf, divzero}
        int           lat;
        int           t0;
    } exp_t;

    exp_t sb1[$];
    exp_t sb2[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [W-1:0] hi, input logic [W-1:0] lo,
                                input logic neg, input logic carry, input logic ovf,
                                input logic dz, input int lat);
        exp_t e;
        e.tag   = tag;
        e.hi    = hi;
        e.lo    = lo;
        e.flags = {({hi, lo} == 64'd0), neg, carry, ovf, dz};
        e.lat   = lat;
        e.t0    = 0;
        return e;
    endfunction

    task automatic cmp(input exp_t e, input logic [W-1:0] hi, input logic [W-1:0] lo,
                       input logic [4:0] flags);
        chk({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
        chk({e.tag, "_flags"}, 64'(flags), 64'(e.flags));
        chk({e.tag, "_latency"}, 64'(cyc - e.t0), 64'(e.lat));
    endtask

    always @(negedge clk) begin
        if (!rst && done1) begin
            if (sb1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done_dut1: got oDone=1 required no result pending");
            end else begin
                cmp(sb1.pop_front(), hi1, lo1, {zero1, neg1, carry1, ovf1, dz1});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done2) begin
            if (sb2.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done_dut2: got oDone=1 required no result pending");
            end else begin
                cmp(sb2.pop_front(), hi2, lo2, {zero2, neg2, carry2, ovf2, dz2});
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input exp_t e);
        @(negedge clk);
        ctrl   = op;
        a      = va;
        b      = vb;
        start1 = 1'b1;
        e.t0   = cyc;
        sb1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 200 && (sb1.size() != 0 || sb2.size() != 0 || busy1 || busy2); i++)
            @(negedge clk);
        if (i == 200) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d results pending required 0", name, sb1.size() + sb2.size());
            sb1.delete();
            sb2.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   i;

        repeat (2) @(negedge clk);
        chk("reset_outputs", {hi1, lo1}, 64'd0);
        chk("reset_flags", 64'({busy1, done1, zero1, neg1, carry1, ovf1, dz1}), 64'd0);
        rst = 1'b0;

        issue(CTRL_ALU_ADD, 32'h7FFF_FFFF, 32'h1, mk("add_ovf", 32'h0, 32'h8000_0000, 1, 0, 1, 0, 1));
        drain("add_ovf");
        issue(CTRL_ALU_SUB, 32'h5, 32'h3, mk("sub_carry", 32'h0, 32'h2, 0, 1, 0, 0, 1));
        drain("sub_carry");
        issue(CTRL_ALU_NEG, 32'h8000_0000, 32'h0, mk("neg_min", 32'h0, 32'h8000_0000, 1, 0, 1, 0, 1));
        drain("neg_min");
        issue(CTRL_ALU_MUL, 32'hFFFF_FFFD, 32'h7, mk("mul_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1, 0, 0, 0, 34));
        drain("mul_neg");
        issue(CTRL_ALU_MUL, 32'h0001_0000, 32'h0001_0000, mk("mul_pos", 32'h1, 32'h0, 0, 0, 0, 0, 34));
        drain("mul_pos");
        issue(CTRL_ALU_DIV, 32'hFFFF_FFF9, 32'h2, mk("div_neg", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1, 0, 0, 0, 34));
        drain("div_neg");
        issue(CTRL_ALU_DIV, 32'h5, 32'h0, mk("div_zero", 32'hFFFF_FFFF, 32'h5, 1, 0, 0, 1, 34));
        drain("div_zero");
        issue(CTRL_ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, mk("div_min", 32'h8000_0000, 32'h0, 1, 0, 0, 0, 34));
        drain("div_min");

        // Start pulse mid-divide must be dropped; a start in the DONE cycle must be taken.
        issue(CTRL_ALU_DIV, 32'd100, 32'd7, mk("div_busy", 32'd14, 32'd2, 0, 0, 0, 0, 34));
        repeat (4) @(negedge clk);
        chk("busy_mid_div", 64'(busy1), 64'd1);
        ctrl   = CTRL_ALU_ADD;
        a      = 32'd9;
        b      = 32'd9;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (i = 0; i < 100 && !done1; i++)
            @(negedge clk);
        chk("div_busy_done_seen", 64'(done1), 64'd1);
        ctrl   = CTRL_ALU_ADD;
        a      = 32'd2;
        b      = 32'd3;
        start1 = 1'b1;
        e      = mk("b2b_add", 32'h0, 32'd5, 0, 0, 0, 0, 1);
        e.t0   = cyc;
        sb1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        drain("b2b_add");

        // Reset in the middle of a divide clears everything immediately.
        issue(CTRL_ALU_DIV, 32'd1000, 32'd3, mk("div_reset", 32'd333, 32'd1, 0, 0, 0, 0, 34));
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {hi1, lo1}, 64'd0);
        chk("rst_mid_flags", 64'({busy1, done1, zero1, neg1, carry1, ovf1, dz1}), 64'd0);
        sb1.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(CTRL_ALU_ADD, 32'd1, 32'd1, mk("add_after_rst", 32'h0, 32'd2, 0, 0, 0, 0, 1));
        drain("add_after_rst");

        issue(CTRL_ALU_SRA, 32'h8000_0000, 32'd31, mk("sra", 32'h0, 32'hFFFF_FFFF, 1, 0, 0, 0, 1));
        drain("sra");
        issue(CTRL_ALU_ROL, 32'h8000_0001, 32'd1, mk("rol", 32'h0, 32'h3, 0, 0, 0, 0, 1));
        drain("rol");
        issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, mk("undef_op", 32'h0, 32'h0, 0, 0, 0, 0, 1));
        drain("undef_op");

        // Two bits per cycle: same product, N = 16.
        @(negedge clk);
        ctrl   = CTRL_ALU_MUL;
        a      = 32'hFFFF_FFFD;
        b      = 32'h7;
        start2 = 1'b1;
        e      = mk("mul_bpc2", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1, 0, 0, 0, 18);
        e.t0   = cyc;
        sb2.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
        drain("mul_bpc2");

        chk("sb_empty", 64'(sb1.size() + sb2.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got simulation still running required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

endmodule
